// File: rtl/result_accumulator.sv
// Frame accumulator: sums 2^LOG2_N add_multiply results and reports the frame sum and mean.
// Define AVG_ROUND_EN for a round-half-up mean; the default build truncates toward minus infinity.
module result_accumulator #(
    parameter int LOG2_N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              clr,
    input  logic              in_valid,
    input  logic signed [9:0] Y_in,
    output logic              out_valid,
    output logic signed [13:0] sum,
    output logic signed [9:0] y_avg,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a sample is taken on any rising edge with ce=1, in_valid=1 and clr=0;
    // out_valid has no ready, it stays high for as long as the DUMP state is held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [LOG2_N-1:0] CNT_ONE  = 1;
    localparam logic [LOG2_N-1:0] CNT_LAST = {LOG2_N{1'b1}};

    state_t                    state_q, state_d;
    logic signed [13:0]        acc_q, acc_d;
    logic [LOG2_N-1:0]         count_q, count_d;
    logic signed [13:0]        sum_q, sum_d;
    logic signed [9:0]         avg_q, avg_d;

    logic signed [13:0]        y_ext;
    logic signed [13:0]        total;
    logic signed [14:0]        total_w;
    logic signed [14:0]        avg_w;

    assign y_ext   = {{4{Y_in[9]}}, Y_in};
    assign total   = acc_q + y_ext;
    assign total_w = {total[13], total};

`ifdef AVG_ROUND_EN
    localparam logic signed [14:0] ROUND_BIAS = 15'sd1 <<< (LOG2_N - 1);
    assign avg_w = (total_w + ROUND_BIAS) >>> LOG2_N;
`else
    assign avg_w = total_w >>> LOG2_N;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            avg_q   <= avg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        avg_d   = avg_q;
        if (ce) begin
            if (clr) begin
                // Abort drops the partial frame but keeps the last reported result.
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
            end else begin
                case (state_q)
                    ACC: begin
                        if (in_valid) begin
                            if (count_q == CNT_LAST) begin
                                state_d = DUMP;
                                sum_d   = total;
                                avg_d   = 10'(avg_w);
                                acc_d   = '0;
                                count_d = '0;
                            end else begin
                                acc_d   = total;
                                count_d = count_q + CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DUMP both open a new frame on a sample, else rest in IDLE.
                        if (in_valid) begin
                            state_d = ACC;
                            acc_d   = y_ext;
                            count_d = CNT_ONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid = (state_q == DUMP);
    assign busy      = (state_q == ACC);
    assign sum       = sum_q;
    assign y_avg     = avg_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: directed frames plus random traffic, checked against a
// frame-level integer model and a scoreboard of completed-frame results.
module tb_result_accumulator;
    localparam int LOG2_N = 2;
    localparam int N = 1 << LOG2_N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce = 1'b0;
    logic clr = 1'b0;
    logic in_valid = 1'b0;
    logic [9:0] y_in = '0;
    logic out_valid;
    logic signed [13:0] sum;
    logic signed [9:0] y_avg;
    logic busy;
    logic [1:0] dbg_state;

    result_accumulator #(.LOG2_N(LOG2_N)) dut (
        .clk(clk), .rst(rst), .ce(ce), .clr(clr), .in_valid(in_valid), .Y_in(y_in),
        .out_valid(out_valid), .sum(sum), .y_avg(y_avg), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    int frame[$];
    bit m_ov = 0;
    bit m_busy = 0;
    int m_sum = 0;
    int m_avg = 0;
    bit mon_en = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int a, input int n);
        int q;
        q = a / n;
        if ((a % n != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int frame_mean(input int s);
`ifdef AVG_ROUND_EN
        return floordiv(s + N / 2, N);
`else
        return floordiv(s, N);
`endif
    endfunction

    // Driver: apply inputs at negedge, then advance the model at the edge that samples them.
    task automatic cyc(input bit r, input bit c, input bit cl, input bit v, input int yv);
        int s;
        @(negedge clk);
        rst = r; ce = c; clr = cl; in_valid = v; y_in = 10'(yv);
        @(posedge clk);
        if (r) begin
            frame.delete();
            m_ov = 0; m_sum = 0; m_avg = 0;
        end else if (c) begin
            m_ov = 0;
            if (cl) begin
                frame.delete();
            end else if (v) begin
                frame.push_back(int'($signed(10'(yv))));
                if (frame.size() == N) begin
                    s = 0;
                    foreach (frame[i]) s += frame[i];
                    m_sum = s;
                    m_avg = frame_mean(s);
                    exp_q.push_back({m_sum[13:0], m_avg[9:0]});
                    m_ov = 1;
                    frame.delete();
                end
            end
        end
        m_busy = (frame.size() > 0);
    endtask

    task automatic sample(input int yv);
        cyc(0, 1, 0, 1, yv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
    endtask

    // Monitor: per-cycle status against the model, frame results against the scoreboard.
    initial begin
        bit prev_ov;
        bit ce_last;
        logic [23:0] exp;
        prev_ov = 0;
        wait (mon_en);
        forever begin
            @(posedge clk);
            ce_last = ce;
            @(negedge clk);
            chk("out_valid", int'(out_valid), int'(m_ov));
            chk("busy", int'(busy), int'(m_busy));
            chk("sum_hold", int'(sum), m_sum);
            chk("avg_hold", int'(y_avg), m_avg);
            if (out_valid && (!prev_ov || ce_last)) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: got sum %0d with no frame expected", sum);
                end else begin
                    exp = exp_q.pop_front();
                    chk("frame_sum", int'(sum), int'($signed(exp[23:10])));
                    chk("frame_avg", int'(y_avg), int'($signed(exp[9:0])));
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        cyc(1, 1, 0, 0, 0);
        mon_en = 1;
        cyc(1, 1, 0, 0, 0);

        sample(20); sample(24); sample(-128); sample(100);
        idle(2);

        sample(1); sample(1); sample(1); sample(0); idle(1);
        sample(-1); sample(-1); sample(-1); sample(0); idle(1);
        for (int i = 0; i < 4; i++) sample(511);
        idle(1);
        for (int i = 0; i < 4; i++) sample(-512);
        idle(1);

        sample(50); sample(50);
        cyc(0, 1, 1, 1, 50);
        for (int i = 0; i < 4; i++) sample(10);
        idle(2);

        for (int i = 0; i < 8; i++) sample(5);
        idle(2);
        for (int i = 0; i < 4; i++) sample(5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 99);
        for (int i = 0; i < 4; i++) sample(5);
        idle(2);

        for (int i = 0; i < 3; i++) sample(3);
        cyc(1, 0, 0, 1, 3);
        for (int i = 0; i < 4; i++) sample(7);
        idle(2);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
                int'($signed(10'($urandom_range(0, 1023)))));
        end
        idle(3);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
